// File: rtl/midi_msg_scheduler.sv
// MIDI message scheduler: drains real-time and data byte FIFOs, assembles messages onto a valid/ready bus.
// Optional: define MIDI_ACTIVE_SENSE_DROP_EN to silently drop 0xFE active-sensing bytes.
module midi_msg_scheduler #(
  parameter int SYSEX_PASS = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 midi_system_clock,
  input  logic                 midi_rst_n,
  input  logic [7:0]           rt_fifo_dout,
  input  logic                 rt_fifo_empty,
  output logic                 rt_fifo_rd,
  input  logic [7:0]           data_fifo_dout,
  input  logic                 data_fifo_empty,
  output logic                 data_fifo_rd,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [7:0]           msg_status,
  output logic [6:0]           msg_data1,
  output logic [6:0]           msg_data2,
  output logic [1:0]           msg_len,
  output logic                 msg_is_rt,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [0:0] {IDLE, COLLECT} state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_run_status, w_run_status_nxt;
  logic                 r_sysex_active, w_sysex_nxt;
  logic [7:0]           r_cur_status, w_cur_status_nxt;
  logic [6:0]           r_data1, w_data1_nxt;
  logic                 r_have1, w_have1_nxt;
  logic                 r_need2, w_need2_nxt;
  logic                 r_msg_valid, r_msg_is_rt, r_err_pulse;
  logic [7:0]           r_msg_status;
  logic [6:0]           r_msg_data1, r_msg_data2;
  logic [1:0]           r_msg_len;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic       w_slot_free, w_rt_pop, w_data_pop;
  logic       w_emit, w_emit_rt, w_err;
  logic [7:0] w_emit_status;
  logic [6:0] w_emit_d1, w_emit_d2;
  logic [1:0] w_emit_len;

  assign w_slot_free  = ~r_msg_valid | msg_ready;
  assign w_rt_pop     = w_slot_free & ~rt_fifo_empty;
  assign w_data_pop   = w_slot_free & rt_fifo_empty & ~data_fifo_empty;
  assign rt_fifo_rd   = w_rt_pop;
  assign data_fifo_rd = w_data_pop;

  // Byte decode; the bit7 of r_run_status doubles as its valid flag.
  always_comb begin
    w_state_nxt      = r_state;
    w_run_status_nxt = r_run_status;
    w_sysex_nxt      = r_sysex_active;
    w_cur_status_nxt = r_cur_status;
    w_data1_nxt      = r_data1;
    w_have1_nxt      = r_have1;
    w_need2_nxt      = r_need2;
    w_emit           = 1'b0;
    w_emit_rt        = 1'b0;
    w_emit_status    = 8'h00;
    w_emit_d1        = 7'h00;
    w_emit_d2        = 7'h00;
    w_emit_len       = 2'd0;
    w_err            = 1'b0;
    if (w_rt_pop) begin
`ifdef MIDI_ACTIVE_SENSE_DROP_EN
      w_emit        = (rt_fifo_dout != 8'hFE);
`else
      w_emit        = 1'b1;
`endif
      w_emit_rt     = 1'b1;
      w_emit_status = rt_fifo_dout;
    end else if (w_data_pop) begin
      if (!data_fifo_dout[7]) begin
        if (r_state == COLLECT) begin
          if (r_need2 && !r_have1) begin
            w_data1_nxt = data_fifo_dout[6:0];
            w_have1_nxt = 1'b1;
          end else begin
            w_emit        = 1'b1;
            w_emit_status = r_cur_status;
            w_emit_len    = r_need2 ? 2'd2 : 2'd1;
            w_emit_d1     = r_need2 ? r_data1 : data_fifo_dout[6:0];
            w_emit_d2     = r_need2 ? data_fifo_dout[6:0] : 7'h00;
            w_have1_nxt   = 1'b0;
            w_state_nxt   = IDLE;
          end
        end else if (r_sysex_active) begin
          w_emit        = (SYSEX_PASS != 0);
          w_emit_status = 8'hF0;
          w_emit_len    = 2'd1;
          w_emit_d1     = data_fifo_dout[6:0];
        end else if (r_run_status[7]) begin
          if (r_run_status[7:5] == 3'b110) begin
            w_emit        = 1'b1;
            w_emit_status = r_run_status;
            w_emit_len    = 2'd1;
            w_emit_d1     = data_fifo_dout[6:0];
          end else begin
            w_cur_status_nxt = r_run_status;
            w_data1_nxt      = data_fifo_dout[6:0];
            w_have1_nxt      = 1'b1;
            w_need2_nxt      = 1'b1;
            w_state_nxt      = COLLECT;
          end
        end else begin
          w_err = 1'b1;
        end
      end else if (data_fifo_dout >= 8'hF8) begin
        w_emit        = 1'b1;
        w_emit_status = data_fifo_dout;
      end else begin
        // Any status byte aborts a partial message, then is decoded as if in IDLE.
        w_err       = (r_state == COLLECT);
        w_state_nxt = IDLE;
        w_have1_nxt = 1'b0;
        if (data_fifo_dout < 8'hF0) begin
          w_cur_status_nxt = data_fifo_dout;
          w_run_status_nxt = data_fifo_dout;
          w_need2_nxt      = (data_fifo_dout[7:5] != 3'b110);
          w_sysex_nxt      = 1'b0;
          w_state_nxt      = COLLECT;
        end else begin
          case (data_fifo_dout)
            8'hF0: begin
              w_sysex_nxt      = 1'b1;
              w_run_status_nxt = 8'h00;
              w_emit           = (SYSEX_PASS != 0);
              w_emit_status    = 8'hF0;
            end
            8'hF7: begin
              if (r_sysex_active) begin
                w_sysex_nxt   = 1'b0;
                w_emit        = (SYSEX_PASS != 0);
                w_emit_status = 8'hF7;
              end else begin
                w_err = 1'b1;
              end
            end
            8'hF1, 8'hF2, 8'hF3: begin
              w_cur_status_nxt = data_fifo_dout;
              w_run_status_nxt = 8'h00;
              w_need2_nxt      = (data_fifo_dout == 8'hF2);
              w_sysex_nxt      = 1'b0;
              w_state_nxt      = COLLECT;
            end
            default: begin
              w_run_status_nxt = 8'h00;
              w_sysex_nxt      = 1'b0;
              w_emit           = 1'b1;
              w_emit_status    = data_fifo_dout;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge midi_system_clock or negedge midi_rst_n) begin
    if (!midi_rst_n) begin
      r_state        <= IDLE;
      r_run_status   <= 8'h00;
      r_sysex_active <= 1'b0;
      r_cur_status   <= 8'h00;
      r_data1        <= 7'h00;
      r_have1        <= 1'b0;
      r_need2        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_run_status   <= w_run_status_nxt;
      r_sysex_active <= w_sysex_nxt;
      r_cur_status   <= w_cur_status_nxt;
      r_data1        <= w_data1_nxt;
      r_have1        <= w_have1_nxt;
      r_need2        <= w_need2_nxt;
    end
  end

  // Output slot: a new message may load in the same cycle the old one is accepted.
  always_ff @(posedge midi_system_clock or negedge midi_rst_n) begin
    if (!midi_rst_n) begin
      r_msg_valid  <= 1'b0;
      r_msg_status <= 8'h00;
      r_msg_data1  <= 7'h00;
      r_msg_data2  <= 7'h00;
      r_msg_len    <= 2'd0;
      r_msg_is_rt  <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      if (w_emit) begin
        r_msg_valid  <= 1'b1;
        r_msg_status <= w_emit_status;
        r_msg_data1  <= w_emit_d1;
        r_msg_data2  <= w_emit_d2;
        r_msg_len    <= w_emit_len;
        r_msg_is_rt  <= w_emit_rt;
      end else if (msg_ready) begin
        r_msg_valid <= 1'b0;
      end
      r_err_pulse <= w_err;
      if (w_err && (r_err_count != {ERR_CNT_W{1'b1}}))
        r_err_count <= r_err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign msg_valid  = r_msg_valid;
  assign msg_status = r_msg_status;
  assign msg_data1  = r_msg_data1;
  assign msg_data2  = r_msg_data2;
  assign msg_len    = r_msg_len;
  assign msg_is_rt  = r_msg_is_rt;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;

endmodule

// File: doc/midi_msg_scheduler.md
Name: midi_msg_scheduler

Overview:
- Drains the two byte FIFOs fed by the MIDI UART receiver: the real-time FIFO (0xF8–0xFF) and the data FIFO (all other bytes).
- Arbitrates between them with strict real-time priority.
- Assembles data-FIFO bytes into complete MIDI messages, including running status and SysEx streaming.
- Presents one message at a time on a valid/ready message bus to the downstream MIDI-to-bus logic.

Parameters:
- SYSEX_PASS, 1, 1 = SysEx bytes forwarded as messages; 0 = SysEx bytes (0xF0, payload, 0xF7) popped and dropped.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- midi_system_clock  in  1  block clock
- midi_rst_n  in  1  asynchronous active-low reset
- rt_fifo_dout  in  8  real-time FIFO head byte (first-word-fall-through)
- rt_fifo_empty  in  1  real-time FIFO empty
- rt_fifo_rd  out  1  real-time FIFO pop strobe
- data_fifo_dout  in  8  data FIFO head byte (first-word-fall-through)
- data_fifo_empty  in  1  data FIFO empty
- data_fifo_rd  out  1  data FIFO pop strobe
- msg_valid  out  1  message slot full
- msg_ready  in  1  downstream accepts the message
- msg_status  out  8  status byte of the message
- msg_data1  out  7  first data byte
- msg_data2  out  7  second data byte
- msg_len  out  2  number of valid data bytes, 0..2
- msg_is_rt  out  1  message came from the real-time FIFO
- err_pulse  out  1  one-cycle pulse per protocol error
- err_count  out  ERR_CNT_W  saturating count of errors

Behaviour:
- Reset (async, midi_rst_n=0):
  - All outputs 0; state IDLE; running status cleared; sysex_active=0.
  - Reset mid-message discards any partial message and the held output.
- Slot free: slot_free = ~msg_valid | msg_ready. No pop occurs while the slot is not free.
- Pop rules:
  - Combinational pop; at most one strobe per cycle.
  - rt_fifo_rd = slot_free & ~rt_fifo_empty.
  - data_fifo_rd = slot_free & rt_fifo_empty & ~data_fifo_empty.
  - A strobe is never asserted when the corresponding empty=1.
- Output handshake:
  - A popped byte that completes a message loads the slot at the same edge, so msg_valid=1 the next cycle (latency 1 from the pop).
  - Outputs are held stable while msg_valid & ~msg_ready.
  - msg_valid clears on acceptance unless a new message loads in that same cycle (back-to-back, 1 message/cycle).
- Real-time byte:
  - Emitted as status=byte, len=0, is_rt=1.
  - Allowed in any state; COLLECT progress (status, captured data bytes, count) is preserved. Real-time bytes interleaved inside a message must not corrupt it.
- States: IDLE, COLLECT.
  - In IDLE with status byte S:
    - 0x80–0xBF, 0xE0–0xEF: need=2; running status := S; go to COLLECT.
    - 0xC0–0xDF: need=1; running status := S; go to COLLECT.
    - 0xF1, 0xF3: need=1; running status cleared; go to COLLECT.
    - 0xF2: need=2; running status cleared; go to COLLECT.
    - 0xF6, 0xF4, 0xF5: emit len=0 immediately; running status cleared.
    - 0xF0: sysex_active=1; emit status 0xF0 len=0; running status cleared.
    - 0xF7: if sysex_active, emit F7 len=0 and clear sysex_active; otherwise count as an error and drop.
  - In IDLE with data byte D (bit7=0):
    - If sysex_active: emit status 0xF0, len=1, data1=D.
    - Else if running status is valid: start COLLECT with the running status, D already captured as the first data byte. If need=1, emit immediately and stay in IDLE.
    - Else: drop D; error (orphan).
  - In COLLECT:
    - Data byte: store it; when count==need, emit (data2=0 when len=1) and return to IDLE.
    - Status byte: partial message discarded; error (truncated); the byte is processed as in IDLE in the same cycle.
  - With SYSEX_PASS=0: 0xF0, SysEx payload and 0xF7 are popped with no message emitted; sysex tracking still operates.
- Error reporting:
  - err_pulse is high the cycle after an erroneous pop.
  - err_count increments and saturates at all-ones.
  - A truncation and the new message can coincide; only one error is counted per pop.

Optional Feature:
- Macro MIDI_ACTIVE_SENSE_DROP_EN.
- Defined: 0xFE from the real-time FIFO is popped (same pop rules) and never emitted; all other real-time bytes are unchanged.
- Undefined: 0xFE is emitted like any other real-time byte.

Test Plan:
- Data FIFO 0x90,0x3C,0x64 → one message: status=0x90, data1=0x3C, data2=0x64, len=2, is_rt=0; msg_valid 1 cycle after the third pop.
- Running status: 0x90,0x3C,0x64,0x40,0x00 → two messages; the second is 0x90/0x40/0x00 len=2.
- Data 0xB0,0x07 and real-time 0xF8 pushed mid-message, then data 0x7F → order: F8 (is_rt=1, len=0), then B0/07/7F len=2.
- Hold msg_ready=0 with 3 queued messages → no pops, outputs stable; then msg_ready=1 → messages on 3 consecutive cycles.
- 0x45 after reset (no running status) → dropped, err_pulse once, err_count=1. Then 0x90,0x3C,0x80,0x3C,0x00 → error for the truncated 0x90; then 0x80/3C/00 emitted; err_count=2.
- Assert midi_rst_n=0 mid-COLLECT with msg_valid=1 → msg_valid=0 immediately; after release, a data byte with no running status is flagged as orphan.
